// File: rtl/picorv32_pcpi_galois_iter.sv
// picorv32_pcpi_galois_iter: iterative PCPI coprocessor for carry-less and GF(2^m) multiply
module picorv32_pcpi_galois_iter #(
    parameter int          DATA_WIDTH     = 32,
    parameter int          BITS_PER_CYCLE = 1,
    parameter int          DEFAULT_M      = DATA_WIDTH,
    parameter logic [31:0] DEFAULT_POLY   = 32'h0000008D
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready
);
    localparam int W  = DATA_WIDTH;
    localparam int K  = BITS_PER_CYCLE;
    localparam int W2 = 2 * W;
    localparam logic [1:0] OP_CLMUL  = 2'd0;
    localparam logic [1:0] OP_CLMULH = 2'd1;
    localparam logic [1:0] OP_CFG    = 2'd2;
    localparam logic [1:0] OP_GF     = 2'd3;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_RED, S_DONE} state_t;
    state_t       r_state, w_next;
    logic [1:0]   r_op;
    logic [5:0]   r_m, r_lm, r_cnt, r_idx;
    logic [W-1:0] r_poly, r_b;
    logic [W2-1:0] r_a, r_acc, r_lp, w_acc_mul, w_acc_red, w_p_cur;
    logic [W-1:0] w_mask, w_lmask, w_a_in, w_b_in;
    logic [31:0]  r_rd;
    logic [1:0]   w_op;
    logic [5:0]   w_cfg_m;
    logic         w_match, w_accept, w_cfg_bad, w_unused;
    // Bit mask selecting the low m bits of a W-bit word
    function automatic logic [W-1:0] low_mask(input logic [5:0] m);
        logic [W:0] t;
        t = ((W+1)'(1) << m) - (W+1)'(1);
        return t[W-1:0];
    endfunction
    assign w_match   = pcpi_valid && pcpi_insn[6:0] == 7'b0110011 &&
                       pcpi_insn[31:25] == 7'b0000100 && !pcpi_insn[14];
    assign w_accept  = r_state == S_IDLE && w_match && !pcpi_ready;
    assign w_op      = pcpi_insn[13:12];
    assign w_cfg_m   = pcpi_rs1[5:0];
    assign w_cfg_bad = w_cfg_m < 6'd2 || int'(w_cfg_m) > W;
    assign w_mask    = low_mask(r_m);
    assign w_lmask   = low_mask(r_lm);
    assign w_p_cur   = W2'(r_poly & w_mask) | (W2'(1) << r_m);
    assign w_a_in    = w_op == OP_GF ? pcpi_rs1[W-1:0] & w_mask : pcpi_rs1[W-1:0];
    assign w_b_in    = w_op == OP_GF ? pcpi_rs2[W-1:0] & w_mask : pcpi_rs2[W-1:0];
    assign w_acc_red = r_acc ^ (r_acc[r_idx] ? r_lp << (r_idx - r_lm) : '0);
    assign w_unused  = ^{pcpi_insn[24:15], pcpi_insn[11:7]};
    // Fold K multiplier bits (LSB first) into the accumulator
    always_comb begin
        w_acc_mul = r_acc;
        for (int k = 0; k < K; k++) w_acc_mul = w_acc_mul ^ (r_b[k] ? r_a << k : '0);
    end
    // State register
    always_ff @(posedge clk) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end
    // Next state; a dropped pcpi_valid aborts MUL/RED without a result
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  w_next = w_accept ? (w_op == OP_CFG ? S_DONE : S_MUL) : S_IDLE;
            S_MUL:   w_next = !pcpi_valid ? S_IDLE :
                              r_cnt == 6'd1 ? (r_op == OP_GF ? S_RED : S_DONE) : S_MUL;
            S_RED:   w_next = !pcpi_valid ? S_IDLE : r_idx == r_lm ? S_DONE : S_RED;
            default: w_next = S_IDLE;
        endcase
    end
    // Handshake outputs; pcpi_rd shows the result in DONE and holds it afterwards
    always_comb begin
        pcpi_ready = r_state == S_DONE;
        pcpi_wr    = r_state == S_DONE;
        pcpi_wait  = r_state == S_MUL || r_state == S_RED;
        pcpi_rd    = r_state != S_DONE ? r_rd :
                     r_op == OP_CLMULH ? 32'(r_acc[W2-1:W]) :
                     r_op == OP_GF     ? 32'(r_acc[W-1:0] & w_lmask) : 32'(r_acc[W-1:0]);
    end
    // Datapath: operand latch, shift-and-xor multiply, bit-serial reduction, field config
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_m    <= 6'(DEFAULT_M);
            r_poly <= DEFAULT_POLY[W-1:0];
            r_rd   <= '0;
            r_op   <= OP_CLMUL;
            r_lm   <= '0;
            r_lp   <= '0;
            r_cnt  <= '0;
            r_idx  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
        end else begin
            r_rd <= pcpi_rd;
            if (w_accept) begin
                r_op  <= w_op;
                r_lm  <= r_m;
                r_lp  <= w_p_cur;
                r_cnt <= 6'(W / K);
                r_a   <= W2'(w_a_in);
                r_b   <= w_b_in;
                r_acc <= W2'(w_op == OP_CFG && w_cfg_bad);
                if (w_op == OP_CFG && !w_cfg_bad) begin
                    r_m    <= w_cfg_m;
                    r_poly <= pcpi_rs2[W-1:0];
                end
            end else if (r_state == S_MUL) begin
                r_acc <= w_acc_mul;
                r_a   <= r_a << K;
                r_b   <= r_b >> K;
                r_cnt <= r_cnt - 6'd1;
                r_idx <= (r_lm << 1) - 6'd2;
            end else if (r_state == S_RED) begin
                r_acc <= w_acc_red;
                r_idx <= r_idx - 6'd1;
            end
        end
    end
endmodule

// File: tb/tb_picorv32_pcpi_galois_iter.sv
// tb_picorv32_pcpi_galois_iter: directed checks of the iterative Galois PCPI coprocessor (K=1 and K=4)
module tb_picorv32_pcpi_galois_iter;
    logic        clk = 0;
    logic        resetn = 0;
    logic        valid1 = 0, valid4 = 0;
    logic [31:0] insn = 0, rs1 = 0, rs2 = 0;
    logic        wr1, wait1, rdy1, wr4, wait4, rdy4;
    logic [31:0] rd1, rd4;
    int          n_vec = 0, n_bad = 0;
    logic [31:0] rd;
    int          lat, wlo, cnt;

    always #5 clk = ~clk;

    picorv32_pcpi_galois_iter u_k1 (
        .clk(clk), .resetn(resetn), .pcpi_valid(valid1), .pcpi_insn(insn),
        .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(wr1), .pcpi_rd(rd1),
        .pcpi_wait(wait1), .pcpi_ready(rdy1)
    );

    picorv32_pcpi_galois_iter #(.BITS_PER_CYCLE(4)) u_k4 (
        .clk(clk), .resetn(resetn), .pcpi_valid(valid4), .pcpi_insn(insn),
        .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(wr4), .pcpi_rd(rd4),
        .pcpi_wait(wait4), .pcpi_ready(rdy4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3);
        return {7'b0000100, 10'd0, f3, 5'd0, 7'b0110011};
    endfunction

    // Issue one instruction to the selected DUT and wait (bounded) for its ready pulse
    task automatic run(input logic sel, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] r, output int l, output int wl);
        @(negedge clk);
        insn = mk(f3);
        rs1 = a;
        rs2 = b;
        if (sel) valid4 = 1; else valid1 = 1;
        r = 32'hDEADBEEF;
        l = 0;
        wl = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            l++;
            if (sel ? rdy4 : rdy1) begin
                r = sel ? rd4 : rd1;
                check("wr_with_ready", 32'(sel ? wr4 : wr1), 32'd1);
                check("wait_in_done", 32'(sel ? wait4 : wait1), 32'd0);
                break;
            end
            if (!(sel ? wait4 : wait1)) wl++;
        end
        @(negedge clk);
        valid1 = 0;
        valid4 = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd", rd1, 32'd0);
        check("rst_flags", {29'd0, wr1, wait1, rdy1}, 32'd0);
        @(negedge clk);
        resetn = 1;

        run(0, 3'd0, 32'hA, 32'hE, rd, lat, wlo);
        check("clmul_rd", rd, 32'h0000006C);
        check("clmul_lat", 32'(lat), 32'd33);
        check("clmul_wait_hi", 32'(wlo), 32'd0);

        run(0, 3'd1, 32'h80000000, 32'h80000000, rd, lat, wlo);
        check("clmulh_msb", rd, 32'h40000000);
        run(0, 3'd0, 32'h80000000, 32'h80000000, rd, lat, wlo);
        check("clmul_msb", rd, 32'h00000000);

        run(0, 3'd2, 32'd8, 32'h1B, rd, lat, wlo);
        check("cfg8_rd", rd, 32'd0);
        check("cfg8_lat", 32'(lat), 32'd1);
        run(0, 3'd3, 32'h57, 32'h83, rd, lat, wlo);
        check("gf8_rd", rd, 32'h000000C1);
        check("gf8_lat", 32'(lat), 32'd40);
        run(0, 3'd3, 32'h157, 32'h13, rd, lat, wlo);
        check("gf8_mask", rd, 32'h000000FE);

        run(0, 3'd2, 32'd1, 32'h3, rd, lat, wlo);
        check("cfg_m1_rej", rd, 32'd1);
        run(0, 3'd2, 32'd40, 32'h3, rd, lat, wlo);
        check("cfg_m40_rej", rd, 32'd1);
        run(0, 3'd3, 32'h57, 32'h83, rd, lat, wlo);
        check("gf8_after_rej", rd, 32'h000000C1);

        @(negedge clk);
        insn = mk(3'd5);
        valid1 = 1;
        cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (wait1 || rdy1) cnt++;
        end
        @(negedge clk);
        valid1 = 0;
        check("f3_5_unclaimed", 32'(cnt), 32'd0);

        run(0, 3'd2, 32'd2, 32'h3, rd, lat, wlo);
        check("cfg2_rd", rd, 32'd0);
        run(0, 3'd3, 32'h2, 32'h2, rd, lat, wlo);
        check("gf2_rd", rd, 32'h3);
        check("gf2_lat", 32'(lat), 32'd34);

        @(negedge clk);
        insn = mk(3'd0);
        rs1 = 32'hA;
        rs2 = 32'hE;
        valid1 = 1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        resetn = 0;
        @(posedge clk);
        #1;
        check("midrst_rd", rd1, 32'd0);
        check("midrst_flags", {29'd0, wr1, wait1, rdy1}, 32'd0);
        @(negedge clk);
        resetn = 1;
        valid1 = 0;
        cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (rdy1) cnt++;
        end
        check("midrst_no_ready", 32'(cnt), 32'd0);
        run(0, 3'd3, 32'h2, 32'h80000000, rd, lat, wlo);
        check("gf32_default", rd, 32'h0000008D);
        check("gf32_lat", 32'(lat), 32'd64);

        @(negedge clk);
        insn = mk(3'd3);
        rs1 = 32'h2;
        rs2 = 32'h80000000;
        valid1 = 1;
        repeat (38) @(posedge clk);
        #1;
        check("in_red_wait", 32'(wait1), 32'd1);
        @(negedge clk);
        valid1 = 0;
        cnt = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (rdy1 || wait1) cnt++;
        end
        check("abort_red", 32'(cnt), 32'd0);

        run(1, 3'd0, 32'hA, 32'hE, rd, lat, wlo);
        check("k4_clmul_rd", rd, 32'h0000006C);
        check("k4_clmul_lat", 32'(lat), 32'd9);
        run(1, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, rd, lat, wlo);
        check("k4_ones_lo", rd, 32'h55555555);
        run(1, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, rd, lat, wlo);
        check("k4_ones_hi", rd, 32'h55555555);
        run(1, 3'd3, 32'h2, 32'h80000000, rd, lat, wlo);
        check("k4_gf32", rd, 32'h0000008D);
        check("k4_gf32_lat", 32'(lat), 32'd40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
